xalu_ise_issue: RTL
===================

# xalu_ise_issue

Core-side issue/writeback sequencer for the custom-instruction ALU port. Accepts decoded CUSTOM_0..3 instructions from the execute stage and drives the ise_* request bus toward xalu_ise. It captures ise_out when ise_oval returns and presents the result, with its destination register, to writeback through a valid/ready handshake. Requests that no extension claims are turned into an illegal-instruction response.

## Interface
- TIMEOUT, 4: cycles ise_val may stay high without ise_oval before the request is declared illegal; legal range 1..15.
- ise_clk  in  1  core clock; all state changes on rising edge.
- ise_rst  in  1  reset; synchronous, active-low.
- dec_val  in  1  decoded custom instruction valid.
- dec_rdy  out  1  sequencer can accept an instruction.
- dec_fn  in  6  function field; [1:0] is the custom slot (CUSTOM_0..3).
- dec_imm  in  7  funct7 immediate.
- dec_rs1  in  32  operand 1.
- dec_rs2  in  32  operand 2.
- dec_rd  in  5  destination register index.
- flush  in  1  pipeline kill; discards any in-flight instruction.
- ise_fn  out  6  registered copy of dec_fn.
- ise_imm  out  7  registered copy of dec_imm.
- ise_in1  out  32  registered copy of dec_rs1.
- ise_in2  out  32  registered copy of dec_rs2.
- ise_val  out  1  request valid toward xalu_ise.
- ise_oval  in  1  response valid; may rise in the same cycle as ise_val.
- ise_out  in  32  response data; sampled only when ise_oval=1.
- wb_val  out  1  result valid.
- wb_rdy  in  1  writeback accepts result.
- wb_rd  out  5  destination register.
- wb_data  out  32  result; 0 when wb_ill=1.
- wb_ill  out  1  illegal-instruction flag accompanying wb_val.

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE:
  - dec_rdy=1.
  - On dec_val=1 and flush=0, register fn/imm/rs1/rs2/rd, clear the timeout counter, and go to ISSUE.
- ISSUE:
  - ise_val=1 and dec_rdy=0.
  - If ise_oval=1: capture ise_out into wb_data, set wb_ill=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no ise_oval, set wb_data=0 and wb_ill=1, then go to RESP.
- RESP:
  - wb_val=1. wb_rd, wb_data and wb_ill are held stable.
  - On wb_rdy=1, return to IDLE.
  - dec_rdy stays 0 in RESP. There is no back-to-back accept in the same cycle.
- flush=1 in any state: go to IDLE next cycle. ise_val and wb_val deassert next cycle, and no writeback is produced. flush takes priority over dec_val, ise_oval, timeout and wb_rdy.
- An ise_oval arriving outside ISSUE is ignored.
- dec_rd=0 is issued normally. Discarding the write is the register file's job.
- Operand registers change only on accept in IDLE.

## Timing
- Reset values (ise_rst=0 at an edge): state IDLE, ise_val=0, wb_val=0, wb_ill=0, wb_rd=0, wb_data=0, ise_fn/ise_imm/ise_in1/ise_in2=0, counter=0. dec_rdy=1 in the first cycle after reset release.
- Reset while in ISSUE or RESP aborts the instruction and produces no writeback.
- Latency, combinational responder: accept at edge N, ise_val high in cycle N+1, wb_val high in cycle N+2.
- Latency, illegal request: wb_val rises TIMEOUT+1 cycles after accept.
- Throughput: at most one instruction per 3 cycles, plus any wb_rdy stall.
- ise_val, wb_val and dec_rdy are decoded from registered state only, with no combinational path from inputs.

## Configuration
- XALU_ISE_ISSUE_TIMEOUT_EN defined: the timeout counter and illegal path are built as described above.
- XALU_ISE_ISSUE_TIMEOUT_EN undefined:
  - No counter is built and wb_ill is tied to 0.
  - ISSUE waits indefinitely for ise_oval. An unclaimed instruction stalls the sequencer until flush or reset.
  - The TIMEOUT parameter is ignored.

## Structure
- Shared package xalu_ise_pkg holds:
  - state encoding: IDLE=2'd0, ISSUE=2'd1, RESP=2'd2;
  - CUSTOM_0..CUSTOM_3 slot constants;
  - field widths: FN_W=6, IMM_W=7, RD_W=5, XLEN=32.
- One sub-module, xalu_ise_tmo: a 4-bit counter with clear, enable and expiry compare. It is instantiated only under XALU_ISE_ISSUE_TIMEOUT_EN.

## Test plan
- Legal issue:
  - Stimulus: dec_fn=6'b000010, dec_imm=7'h03, rs1=32'h12345678, rs2=32'h9abcdef0, rd=5, with the responder returning 32'hcafef00d combinationally.
  - Required response: ise_val high exactly one cycle; wb_val 2 cycles after accept with wb_rd=5, wb_data=32'hcafef00d, wb_ill=0.
- Illegal issue: dec_fn[1:0]=CUSTOM_0 and the responder never asserts ise_oval. Required response, TIMEOUT=4: wb_val 5 cycles after accept with wb_ill=1 and wb_data=0.
- Writeback backpressure: hold wb_rdy=0 for 3 cycles. Required response: wb_val, wb_rd and wb_data stay stable; dec_rdy=0 throughout; IDLE follows the wb_rdy=1 edge.
- Flush in ISSUE with a delayed responder: flush coincides with ise_oval. Required response: no wb_val, and dec_rdy=1 the next cycle.
- Reset mid-RESP: drive ise_rst=0 while wb_val=1. Required response: all outputs return to reset values next edge; a subsequent instruction completes normally.
- Macro undefined: illegal request held 20 cycles. Required response: ise_val stays high and wb_val stays 0; flush returns the sequencer to IDLE.

Source files
------------

// File: rtl/xalu_ise_pkg.sv
// Shared constants and types for the custom-instruction ALU issue path:
// sequencer state encoding, CUSTOM slot codes and field widths.
package xalu_ise_pkg;

    localparam int FN_W  = 6;
    localparam int IMM_W = 7;
    localparam int RD_W  = 5;
    localparam int XLEN  = 32;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    // Custom slot as carried in fn[1:0]
    localparam logic [1:0] CUSTOM_0 = 2'd0;
    localparam logic [1:0] CUSTOM_1 = 2'd1;
    localparam logic [1:0] CUSTOM_2 = 2'd2;
    localparam logic [1:0] CUSTOM_3 = 2'd3;

    typedef struct packed {
        logic [FN_W-1:0]  fn;
        logic [IMM_W-1:0] imm;
        logic [XLEN-1:0]  rs1;
        logic [XLEN-1:0]  rs2;
        logic [RD_W-1:0]  rd;
    } ise_req_t;

endpackage

// File: rtl/xalu_ise_tmo.sv
// Request timeout counter: counts cycles a request waits unanswered and
// flags expiry once the count reaches TIMEOUT-1.
module xalu_ise_tmo #(
    parameter int TIMEOUT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [3:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= 4'd0;
        end else if (clear) begin
            count_reg <= 4'd0;
        end else if (enable) begin
            count_reg <= count_reg + 4'd1;
        end
    end

    assign expired = (count_reg == 4'(TIMEOUT - 1));

endmodule

// File: rtl/xalu_ise_issue.sv
// Issue/writeback sequencer for the custom-instruction ALU port.
// Define XALU_ISE_ISSUE_TIMEOUT_EN to build the unclaimed-request timeout.
module xalu_ise_issue
    import xalu_ise_pkg::*;
#(
    parameter int TIMEOUT = 4
) (
    input  logic             ise_clk,
    input  logic             ise_rst,
    input  logic             dec_val,
    output logic             dec_rdy,
    input  logic [FN_W-1:0]  dec_fn,
    input  logic [IMM_W-1:0] dec_imm,
    input  logic [XLEN-1:0]  dec_rs1,
    input  logic [XLEN-1:0]  dec_rs2,
    input  logic [RD_W-1:0]  dec_rd,
    input  logic             flush,
    output logic [FN_W-1:0]  ise_fn,
    output logic [IMM_W-1:0] ise_imm,
    output logic [XLEN-1:0]  ise_in1,
    output logic [XLEN-1:0]  ise_in2,
    output logic             ise_val,
    input  logic             ise_oval,
    input  logic [XLEN-1:0]  ise_out,
    output logic             wb_val,
    input  logic             wb_rdy,
    output logic [RD_W-1:0]  wb_rd,
    output logic [XLEN-1:0]  wb_data,
    output logic             wb_ill
);

    if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_timeout
        $error("xalu_ise_issue: TIMEOUT must be in 1..15");
    end

    logic [1:0]      state_reg;
    logic [1:0]      state_next;
    ise_req_t        req_reg;
    logic [XLEN-1:0] data_reg;
    logic            accept;
    logic            responded;
    logic            timeout;

    assign accept    = (state_reg == IDLE) && dec_val && !flush;
    assign responded = (state_reg == ISSUE) && ise_oval;

`ifdef XALU_ISE_ISSUE_TIMEOUT_EN
    logic expired;
    logic ill_reg;

    xalu_ise_tmo #(
        .TIMEOUT(TIMEOUT)
    ) u_tmo (
        .clk    (ise_clk),
        .rst_n  (ise_rst),
        .clear  (accept),
        .enable ((state_reg == ISSUE) && !ise_oval),
        .expired(expired)
    );

    assign timeout = (state_reg == ISSUE) && !ise_oval && expired;

    always_ff @(posedge ise_clk) begin
        if (!ise_rst) begin
            ill_reg <= 1'b0;
        end else if (!flush && (responded || timeout)) begin
            ill_reg <= timeout;
        end
    end

    assign wb_ill = ill_reg;
`else
    // Without the timeout an unclaimed request waits for flush or reset.
    assign timeout = 1'b0;
    assign wb_ill  = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   if (responded || timeout) state_next = RESP;
            RESP:    if (wb_rdy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge ise_clk) begin
        if (!ise_rst) begin
            state_reg <= IDLE;
            req_reg   <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                req_reg <= '{fn: dec_fn, imm: dec_imm, rs1: dec_rs1,
                             rs2: dec_rs2, rd: dec_rd};
            end
            // A flushed response is dropped rather than captured.
            if (!flush && (responded || timeout)) begin
                data_reg <= responded ? ise_out : '0;
            end
        end
    end

    assign dec_rdy = (state_reg == IDLE);
    assign ise_val = (state_reg == ISSUE);
    assign wb_val  = (state_reg == RESP);
    assign ise_fn  = req_reg.fn;
    assign ise_imm = req_reg.imm;
    assign ise_in1 = req_reg.rs1;
    assign ise_in2 = req_reg.rs2;
    assign wb_rd   = req_reg.rd;
    assign wb_data = data_reg;

endmodule
